uart_boot_loader: RTL

UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

---
 rtl/uart_boot_loader.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// UART boot loader: reads a little-endian length header and N data words over the UART
// slave port, writes them to memory and answers with ACK (06) or NAK (15).
// Optional byte echo is enabled by defining UART_LOADER_ECHO_EN.
module uart_boot_loader #(
  parameter int unsigned MAX_WORDS = 16384,
  parameter logic [31:0] UART_BASE = 32'h0
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        start,
  input  logic [31:0] base_adr,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] words_written,
  output logic [31:0] u_adr_o,
  output logic [31:0] u_dat_o,
  output logic        u_we_o,
  output logic        u_stb_o,
  input  logic [31:0] u_dat_i,
  input  logic        u_ack_i,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic        m_ack_i
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_DATA, MEM_WR, TX_RESP, DONE
`ifdef UART_LOADER_ECHO_EN
    , ECHO
`endif
  } state_t;

  state_t      state, state_nxt, after_byte;
  logic [31:0] base_q, len_q, word_q, word_full, m_adr_q, m_dat_q;
  logic [15:0] ww_q;
  logic [7:0]  resp_q, acc_byte;
  logic [1:0]  byte_idx;
  logic        hdr_seen, err_q;
  logic        acc_fire, word_done, len_zero, len_big, last_word;
  logic        unused_dat_hi;
`ifdef UART_LOADER_ECHO_EN
  logic [7:0]  echo_q;
`endif

  assign unused_dat_hi = ^u_dat_i[31:9];

  // A byte is consumed when it leaves RD_DATA, or when its echo write is acked.
  always_comb begin
    acc_fire = 1'b0;
    acc_byte = u_dat_i[7:0];
`ifdef UART_LOADER_ECHO_EN
    if (state == ECHO && u_ack_i) begin
      acc_fire = 1'b1;
      acc_byte = echo_q;
    end
`else
    acc_fire = (state == RD_DATA) && u_dat_i[8];
`endif
    word_full = word_q;
    word_full[{byte_idx, 3'b000} +: 8] = acc_byte;
    word_done = acc_fire && (byte_idx == 2'd3);
    len_zero  = (word_full == '0);
    len_big   = (word_full > 32'(MAX_WORDS));
    last_word = (({16'h0, ww_q} + 32'd1) == len_q);
    if (byte_idx != 2'd3)
      after_byte = RD_REQ;
    else if (hdr_seen)
      after_byte = MEM_WR;
    else if (len_zero || len_big)
      after_byte = TX_RESP;
    else
      after_byte = RD_REQ;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_REQ;
      RD_REQ:  if (u_ack_i) state_nxt = RD_DATA;
`ifdef UART_LOADER_ECHO_EN
      RD_DATA: state_nxt = u_dat_i[8] ? ECHO : RD_REQ;
      ECHO:    if (u_ack_i) state_nxt = after_byte;
`else
      RD_DATA: state_nxt = u_dat_i[8] ? after_byte : RD_REQ;
`endif
      MEM_WR:  if (m_ack_i) state_nxt = last_word ? TX_RESP : RD_REQ;
      TX_RESP: if (u_ack_i) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      base_q   <= '0;
      len_q    <= '0;
      word_q   <= '0;
      m_adr_q  <= '0;
      m_dat_q  <= '0;
      ww_q     <= '0;
      resp_q   <= '0;
      byte_idx <= '0;
      hdr_seen <= 1'b0;
      err_q    <= 1'b0;
`ifdef UART_LOADER_ECHO_EN
      echo_q   <= '0;
`endif
    end else begin
      if (state == IDLE && start) begin
        base_q   <= base_adr;
        len_q    <= '0;
        word_q   <= '0;
        ww_q     <= '0;
        byte_idx <= '0;
        hdr_seen <= 1'b0;
        err_q    <= 1'b0;
      end
`ifdef UART_LOADER_ECHO_EN
      if (state == RD_DATA && u_dat_i[8])
        echo_q <= u_dat_i[7:0];
`endif
      if (acc_fire) begin
        word_q   <= word_full;
        byte_idx <= byte_idx + 2'd1;
        if (word_done) begin
          if (!hdr_seen) begin
            len_q <= word_full;
            if (len_zero) begin
              resp_q <= 8'h06;
            end else if (len_big) begin
              err_q  <= 1'b1;
              resp_q <= 8'h15;
            end else begin
              hdr_seen <= 1'b1;
            end
          end else begin
            m_adr_q <= base_q + {14'h0, ww_q, 2'b00};
            m_dat_q <= word_full;
          end
        end
      end
      if (state == MEM_WR && m_ack_i) begin
        ww_q   <= ww_q + 16'd1;
        resp_q <= 8'h06;
      end
    end
  end

  always_comb begin
    u_stb_o = 1'b0;
    u_we_o  = 1'b0;
    u_adr_o = '0;
    u_dat_o = '0;
    m_stb_o = 1'b0;
    m_we_o  = 1'b0;
    done    = 1'b0;
    case (state)
      RD_REQ: begin
        u_stb_o = 1'b1;
        u_adr_o = UART_BASE;
      end
`ifdef UART_LOADER_ECHO_EN
      ECHO: begin
        u_stb_o = 1'b1;
        u_we_o  = 1'b1;
        u_adr_o = UART_BASE;
        u_dat_o = {24'h0, echo_q};
      end
`endif
      TX_RESP: begin
        u_stb_o = 1'b1;
        u_we_o  = 1'b1;
        u_adr_o = UART_BASE;
        u_dat_o = {24'h0, resp_q};
      end
      MEM_WR: begin
        m_stb_o = 1'b1;
        m_we_o  = 1'b1;
      end
      DONE:    done = !err_q;
      default: ;
    endcase
  end

  assign busy          = (state != IDLE);
  assign err           = err_q;
  assign words_written = ww_q;
  assign m_adr_o       = m_adr_q;
  assign m_dat_o       = m_dat_q;

endmodule
